// File: rtl/play_mode_ctrl_pkg.sv
// Shared definitions for the play-mode controller: mode encodings, rest note,
// FSM state type and a small one-hot helper.
package play_mode_ctrl_pkg;

  localparam logic [2:0] MODE_FREE  = 3'b100;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_LEARN = 3'b001;
  localparam logic [2:0] MODE_NONE  = 3'b000;

  localparam int NOTE_REST = 0;

  localparam int CNT_W = 16;

  typedef enum logic {
    ST_MUTE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_onehot(input logic [2:0] m);
    return $onehot(m);
  endfunction

endpackage

// File: rtl/play_mode_ctrl_if.sv
// Bundle of mode select, source inputs and buzzer/LED outputs for play_mode_ctrl.
// The master side drives mode/keys/sources; the slave side is the controller.
interface play_mode_ctrl_if #(
  parameter int NUM_KEYS = 7,
  parameter int NOTE_W   = 4,
  parameter int OCT_W    = 2
);

  logic [2:0]          mode_i;
  logic [NUM_KEYS-1:0] keys_i;
  logic                oct_up_i;
  logic                oct_down_i;
  logic [NOTE_W-1:0]   note_auto_i;
  logic [NUM_KEYS-1:0] led_auto_i;
  logic [OCT_W-1:0]    oct_auto_i;
  logic [NOTE_W-1:0]   note_learn_i;
  logic [NUM_KEYS-1:0] led_learn_i;

  logic [NOTE_W-1:0]   note_out_o;
  logic [NUM_KEYS-1:0] led_out_o;
  logic [OCT_W-1:0]    octave_out_o;
  logic [2:0]          mode_active_o;
  logic                muting_o;

  modport master (
    output mode_i, keys_i, oct_up_i, oct_down_i,
    output note_auto_i, led_auto_i, oct_auto_i,
    output note_learn_i, led_learn_i,
    input  note_out_o, led_out_o, octave_out_o, mode_active_o, muting_o
  );

  modport slave (
    input  mode_i, keys_i, oct_up_i, oct_down_i,
    input  note_auto_i, led_auto_i, oct_auto_i,
    input  note_learn_i, led_learn_i,
    output note_out_o, led_out_o, octave_out_o, mode_active_o, muting_o
  );

endinterface

// File: rtl/play_mode_ctrl_key_prio_enc.sv
// Free-play key priority encoder: the lowest pressed key wins and is reported
// both as a note code (index+1, 0 = rest) and as a one-hot LED pattern.
module key_prio_enc #(
  parameter int NUM_KEYS = 7,
  parameter int NOTE_W   = 4
) (
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NOTE_W-1:0]   note_o,
  output logic [NUM_KEYS-1:0] led_o
);

  // Scan from the top key down so the last hit (the lowest index) takes priority
  always_comb begin
    note_o = '0;
    led_o  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_i[i]) begin
        note_o    = NOTE_W'(i + 1);
        led_o     = '0;
        led_o[i]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/play_mode_ctrl.sv
// Play-mode controller: selects free/auto/learn sources for the buzzer and
// LEDs, inserting a silent gap of MUTE_CYCLES clocks whenever the mode changes.
// The free-mode octave register saturates and survives trips through other modes.
module play_mode_ctrl
  import play_mode_ctrl_pkg::*;
#(
  parameter int NUM_KEYS    = 7,
  parameter int NOTE_W      = 4,
  parameter int OCT_W       = 2,
  parameter int MUTE_CYCLES = 16,
  parameter int OCT_RESET   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  play_mode_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [OCT_W-1:0] OCT_MAX    = '1;
  localparam logic [OCT_W-1:0] OCT_INIT   = OCT_W'(OCT_RESET);

  state_e              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [NUM_KEYS-1:0] led_q, led_d;
  logic [OCT_W-1:0]    octout_q, octout_d;

  logic [NOTE_W-1:0]   free_note;
  logic [NUM_KEYS-1:0] free_led;

  key_prio_enc #(
    .NUM_KEYS (NUM_KEYS),
    .NOTE_W   (NOTE_W)
  ) u_key_prio_enc (
    .keys_i (bus.keys_i),
    .note_o (free_note),
    .led_o  (free_led)
  );

  // Mode tracking and gap countdown: any new mode value restarts the gap,
  // an invalid mode parks the counter at its reload value
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_MUTE: begin
        if (bus.mode_i != mode_q) begin
          mode_d = bus.mode_i;
          cnt_d  = CNT_RELOAD;
        end else if (!is_onehot(mode_q)) begin
          cnt_d = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.mode_i != mode_q) begin
          state_d = ST_MUTE;
          mode_d  = bus.mode_i;
          cnt_d   = CNT_RELOAD;
        end
      end
      default: begin
        state_d = ST_MUTE;
        mode_d  = MODE_NONE;
        cnt_d   = CNT_RELOAD;
      end
    endcase
  end

  // Saturating octave stepping, only while free mode is actually playing
  always_comb begin
    oct_d = oct_q;
    if (state_q == ST_RUN && mode_q == MODE_FREE) begin
      if (bus.oct_up_i && !bus.oct_down_i && oct_q != OCT_MAX) begin
        oct_d = oct_q + OCT_W'(1);
      end else if (bus.oct_down_i && !bus.oct_up_i && oct_q != '0) begin
        oct_d = oct_q - OCT_W'(1);
      end
    end
  end

  // Output selection for the next cycle: silence during the gap, otherwise the
  // active source; octave output freezes while muted
  always_comb begin
    note_d   = NOTE_W'(NOTE_REST);
    led_d    = '0;
    octout_d = octout_q;
    if (state_d == ST_RUN) begin
      octout_d = oct_d;
      case (mode_q)
        MODE_FREE: begin
          note_d = free_note;
          led_d  = free_led;
        end
        MODE_AUTO: begin
          note_d   = bus.note_auto_i;
          led_d    = bus.led_auto_i;
          octout_d = bus.oct_auto_i;
        end
        MODE_LEARN: begin
          note_d = bus.note_learn_i;
          led_d  = bus.led_learn_i;
        end
        default: begin
          note_d = NOTE_W'(NOTE_REST);
          led_d  = '0;
        end
      endcase
    end
  end

  // State, mode, counter and output registers with asynchronous silencing reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_MUTE;
      mode_q   <= MODE_NONE;
      cnt_q    <= CNT_RELOAD;
      oct_q    <= OCT_INIT;
      note_q   <= NOTE_W'(NOTE_REST);
      led_q    <= '0;
      octout_q <= OCT_INIT;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      oct_q    <= oct_d;
      note_q   <= note_d;
      led_q    <= led_d;
      octout_q <= octout_d;
    end
  end

  assign bus.note_out_o    = note_q;
  assign bus.led_out_o     = led_q;
  assign bus.octave_out_o  = octout_q;
  assign bus.mode_active_o = (state_q == ST_RUN) ? mode_q : MODE_NONE;
  assign bus.muting_o      = (state_q == ST_MUTE);

endmodule

// File: tb/tb_play_mode_ctrl.sv
// Directed bench for play_mode_ctrl: reset values, start-up gap, free-mode key
// priority, octave saturation, mode switching, gap restart, invalid mode and
// asynchronous reset during playback.
module tb_play_mode_ctrl;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  play_mode_ctrl_if #(.NUM_KEYS(7), .NOTE_W(4), .OCT_W(2)) bus ();

  play_mode_ctrl #(
    .NUM_KEYS    (7),
    .NOTE_W      (4),
    .OCT_W       (2),
    .MUTE_CYCLES (16),
    .OCT_RESET   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Power-up values while reset is held low
  task automatic test_reset;
    rst_n = 1'b0;
    bus.mode_i = 3'b000; bus.keys_i = '0; bus.oct_up_i = 1'b0; bus.oct_down_i = 1'b0;
    bus.note_auto_i = 4'd5; bus.led_auto_i = 7'b0010000; bus.oct_auto_i = 2'd2;
    bus.note_learn_i = 4'd9; bus.led_learn_i = 7'b1010101;
    #20;
    testsRun++;
    if (bus.note_out_o !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_note got %0d want 0", bus.note_out_o); end
    testsRun++;
    if (bus.led_out_o !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset_led got %b want 0000000", bus.led_out_o); end
    testsRun++;
    if (bus.octave_out_o !== 2'd1) begin testsFailed++; $display("[TB] FAIL reset_octave got %0d want 1", bus.octave_out_o); end
    testsRun++;
    if (bus.mode_active_o !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_mode_active got %b want 000", bus.mode_active_o); end
    testsRun++;
    if (bus.muting_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_muting got %b want 1", bus.muting_o); end
  endtask

  // Release reset in free mode: 16 silent edges, first note on the 17th
  task automatic test_free_startup;
    bus.mode_i = 3'b100;
    bus.keys_i = 7'b0000101;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      testsRun++;
      if (bus.muting_o !== 1'b1 || bus.note_out_o !== 4'd0) begin
        testsFailed++;
        $display("[TB] FAIL startup_gap edge %0d got muting=%b note=%0d want muting=1 note=0", k, bus.muting_o, bus.note_out_o);
      end
    end
    tick(1);
    testsRun++;
    if (bus.note_out_o !== 4'd1 || bus.led_out_o !== 7'b0000001) begin
      testsFailed++;
      $display("[TB] FAIL startup_note got note=%0d led=%b want note=1 led=0000001", bus.note_out_o, bus.led_out_o);
    end
    testsRun++;
    if (bus.muting_o !== 1'b0 || bus.mode_active_o !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL startup_status got muting=%b mode_active=%b want muting=0 mode_active=100", bus.muting_o, bus.mode_active_o);
    end
    testsRun++;
    if (bus.octave_out_o !== 2'd1) begin testsFailed++; $display("[TB] FAIL startup_octave got %0d want 1", bus.octave_out_o); end
  endtask

  // Lowest pressed key wins, no key gives a rest
  task automatic test_free_keys;
    logic [6:0] keyVec  [4] = '{7'b0000000, 7'b1000000, 7'b0110000, 7'b1111110};
    logic [3:0] expNote [4] = '{4'd0, 4'd7, 4'd5, 4'd2};
    logic [6:0] expLed  [4] = '{7'b0000000, 7'b1000000, 7'b0010000, 7'b0000010};
    for (int v = 0; v < 4; v++) begin
      bus.keys_i = keyVec[v];
      tick(1);
      testsRun++;
      if (bus.note_out_o !== expNote[v] || bus.led_out_o !== expLed[v]) begin
        testsFailed++;
        $display("[TB] FAIL free_keys keys=%b got note=%0d led=%b want note=%0d led=%b",
                 keyVec[v], bus.note_out_o, bus.led_out_o, expNote[v], expLed[v]);
      end
    end
  endtask

  // Octave steps: 1 -> 2 -> 3, saturate at 3, up+down ignored, down to 0 and hold
  task automatic test_octave;
    logic       upVec   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       downVec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] expOct  [8] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    for (int s = 0; s < 8; s++) begin
      bus.oct_up_i   = upVec[s];
      bus.oct_down_i = downVec[s];
      tick(1);
      bus.oct_up_i   = 1'b0;
      bus.oct_down_i = 1'b0;
      testsRun++;
      if (bus.octave_out_o !== expOct[s]) begin
        testsFailed++;
        $display("[TB] FAIL octave step %0d up=%b down=%b got %0d want %0d", s, upVec[s], downVec[s], bus.octave_out_o, expOct[s]);
      end
    end
  endtask

  // Free -> auto: 16 silent edges with octave held, auto source on the 17th
  task automatic test_mode_switch_auto;
    bus.mode_i = 3'b010;
    tick(1);
    testsRun++;
    if (bus.muting_o !== 1'b1 || bus.mode_active_o !== 3'b000 || bus.octave_out_o !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL switch_first got muting=%b mode_active=%b octave=%0d want 1 000 0",
               bus.muting_o, bus.mode_active_o, bus.octave_out_o);
    end
    for (int k = 2; k <= 16; k++) begin
      tick(1);
      testsRun++;
      if (bus.muting_o !== 1'b1 || bus.note_out_o !== 4'd0 || bus.led_out_o !== 7'd0) begin
        testsFailed++;
        $display("[TB] FAIL switch_gap edge %0d got muting=%b note=%0d led=%b", k, bus.muting_o, bus.note_out_o, bus.led_out_o);
      end
    end
    tick(1);
    testsRun++;
    if (bus.note_out_o !== 4'd5 || bus.led_out_o !== 7'b0010000 || bus.octave_out_o !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL auto_play got note=%0d led=%b octave=%0d want 5 0010000 2",
               bus.note_out_o, bus.led_out_o, bus.octave_out_o);
    end
    testsRun++;
    if (bus.mode_active_o !== 3'b010 || bus.muting_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL auto_status got mode_active=%b muting=%b want 010 0", bus.mode_active_o, bus.muting_o);
    end
  endtask

  // Auto -> free, then at counter=5 switch to learn: the gap starts over
  task automatic test_gap_restart;
    bus.mode_i = 3'b100;
    tick(11);
    bus.mode_i = 3'b001;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      testsRun++;
      if (bus.muting_o !== 1'b1 || bus.note_out_o !== 4'd0) begin
        testsFailed++;
        $display("[TB] FAIL restart_gap edge %0d got muting=%b note=%0d want muting=1 note=0", k, bus.muting_o, bus.note_out_o);
      end
    end
    tick(1);
    testsRun++;
    if (bus.note_out_o !== 4'd9 || bus.led_out_o !== 7'b1010101 || bus.mode_active_o !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL learn_play got note=%0d led=%b mode_active=%b want 9 1010101 001",
               bus.note_out_o, bus.led_out_o, bus.mode_active_o);
    end
    testsRun++;
    if (bus.octave_out_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL learn_octave got %0d want 0", bus.octave_out_o); end
  endtask

  // Two-hot mode keeps everything silent; a valid mode then takes the full gap
  task automatic test_invalid_mode;
    bus.mode_i = 3'b110;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      testsRun++;
      if (bus.muting_o !== 1'b1 || bus.note_out_o !== 4'd0 || bus.mode_active_o !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL invalid_mode edge %0d got muting=%b note=%0d mode_active=%b",
                 k, bus.muting_o, bus.note_out_o, bus.mode_active_o);
      end
    end
    bus.mode_i = 3'b001;
    tick(16);
    testsRun++;
    if (bus.muting_o !== 1'b1 || bus.note_out_o !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL invalid_recover_gap got muting=%b note=%0d want 1 0", bus.muting_o, bus.note_out_o);
    end
    tick(1);
    testsRun++;
    if (bus.note_out_o !== 4'd9 || bus.muting_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL invalid_recover_play got note=%0d muting=%b want 9 0", bus.note_out_o, bus.muting_o);
    end
  endtask

  // Reset pulled low mid-note in auto silences outputs without waiting for a clock
  task automatic test_reset_mid_note;
    bus.mode_i = 3'b010;
    tick(17);
    testsRun++;
    if (bus.note_out_o !== 4'd5 || bus.octave_out_o !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_auto got note=%0d octave=%0d want 5 2", bus.note_out_o, bus.octave_out_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (bus.note_out_o !== 4'd0 || bus.led_out_o !== 7'd0 || bus.octave_out_o !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_out got note=%0d led=%b octave=%0d want 0 0000000 1",
               bus.note_out_o, bus.led_out_o, bus.octave_out_o);
    end
    testsRun++;
    if (bus.muting_o !== 1'b1 || bus.mode_active_o !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_status got muting=%b mode_active=%b want 1 000", bus.muting_o, bus.mode_active_o);
    end
    #1;
    rst_n = 1'b1;
    bus.mode_i = 3'b100;
    bus.keys_i = 7'b0000100;
    tick(17);
    testsRun++;
    if (bus.note_out_o !== 4'd3 || bus.octave_out_o !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_free got note=%0d octave=%0d want 3 1", bus.note_out_o, bus.octave_out_o);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_free_startup();
    test_free_keys();
    test_octave();
    test_mode_switch_auto();
    test_gap_restart();
    test_invalid_mode();
    test_reset_mid_note();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
